// File: rtl/atm_display_driver_pkg.sv
// Shared types and seven-segment encoding for the ATM display driver.
// Latency: n/a (types, constants and a pure decode function).
// Backpressure: n/a.
package atm_disp_pkg;

  // Active-low {g,f,e,d,c,b,a} cathode patterns.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/atm_display_driver_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3).
// Latency: 1 capture cycle + 8 shift cycles + 1 done cycle; result valid while done=1.
// Backpressure: none; input changes during a conversion are picked up when it returns to IDLE.
// Ports: clk, rst (sync active-low), bin_in[7:0] -> bcd[11:0] (valid when done), busy, done.
module bin2bcd_seq
  import atm_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  bin_in,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        done
);

  conv_state_t state, state_nxt;
  logic [19:0] sr;         // {bcd accumulator, remaining binary bits}
  logic [7:0]  captured;
  logic        valid;      // a conversion has completed since reset
  logic [2:0]  bit_cnt;
  logic [11:0] adj;

  // Add-3 correction applied to every BCD nibble before each shift.
  always_comb begin
    adj = sr[19:8];
    for (int i = 0; i < 3; i++) begin
      if (sr[8+4*i +: 4] >= 4'd5) adj[4*i +: 4] = sr[8+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!valid || bin_in != captured) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr       <= '0;
      captured <= '0;
      valid    <= 1'b0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (state_nxt == SHIFT) begin
          sr       <= {12'd0, bin_in};
          captured <= bin_in;
          bit_cnt  <= '0;
          busy     <= 1'b1;
        end
        SHIFT: begin
          sr      <= {adj[10:0], sr[7:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        DONE: begin
          valid <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bcd  = sr[19:8];
  assign done = (state == DONE);

endmodule

// File: rtl/atm_display_driver.sv
// Drives the 4-digit common-anode display (status + BCD balance) and the beep buzzer.
// Latency: balance->displayed BCD 10 clk; an/seg registered, 1 clk after index/BCD.
// Backpressure: none; free-running scan, beep is a level input edge-detected here.
// Ports: clk, rst (sync active-low), balance[7:0], status[3:0], beep ->
//        an[3:0] (active-low, bit3 leftmost), seg[6:0] ({g..a} active-low), dp, buzzer, bcd_busy.
// Build option: define ATM_LZ_BLANK_EN to blank leading zeros on the hundreds/tens digits.
module atm_display_driver
  import atm_disp_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int TONE_DIV    = 50000,
  parameter int BEEP_CYCLES = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] balance,
  input  logic [3:0] status,
  input  logic       beep,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       buzzer,
  output logic       bcd_busy
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int TONE_W = $clog2(TONE_DIV + 1);
  localparam int TMR_W  = $clog2(BEEP_CYCLES + 1);

  logic [11:0] conv_bcd;
  logic        conv_done;
  logic [11:0] disp_bcd;

  bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .bin_in (balance),
    .bcd    (conv_bcd),
    .busy   (bcd_busy),
    .done   (conv_done)
  );

  // ---------------- digit scan ----------------
  logic [SCAN_W-1:0] scan_cnt;
  digit_idx_t        idx, idx_nxt;
  logic              scan_tc;
  logic [6:0]        seg_nxt;
  logic [3:0]        d_one, d_ten, d_hun;

  assign scan_tc = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign idx_nxt = scan_tc ? idx + 2'd1 : idx;
  assign d_one   = disp_bcd[3:0];
  assign d_ten   = disp_bcd[7:4];
  assign d_hun   = disp_bcd[11:8];

  // Pattern is chosen for the index being entered so an and seg switch together.
  always_comb begin
    seg_nxt = SEG_BLANK;
    case (idx_nxt)
      2'd0: seg_nxt = seg_decode(d_one);
`ifdef ATM_LZ_BLANK_EN
      2'd1: seg_nxt = (d_hun == 4'd0 && d_ten == 4'd0) ? SEG_BLANK : seg_decode(d_ten);
      2'd2: seg_nxt = (d_hun == 4'd0) ? SEG_BLANK : seg_decode(d_hun);
`else
      2'd1: seg_nxt = seg_decode(d_ten);
      2'd2: seg_nxt = seg_decode(d_hun);
`endif
      default: seg_nxt = seg_decode(status);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= 4'b1111;
      seg      <= SEG_BLANK;
      disp_bcd <= '0;
    end else begin
      scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
      idx      <= idx_nxt;
      an       <= ~(4'b0001 << idx_nxt);
      seg      <= seg_nxt;
      // Only whole results are latched, so a partial conversion is never shown.
      if (conv_done) disp_bcd <= conv_bcd;
    end
  end

  assign dp = 1'b1;

  // ---------------- buzzer ----------------
  logic              beep_q;
  logic              beep_rise;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [TONE_W-1:0] tone_cnt;

  assign beep_rise = beep & ~beep_q;
  assign timer_nxt = beep_rise       ? TMR_W'(BEEP_CYCLES) :
                     (timer != '0)   ? timer - 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      beep_q   <= 1'b0;
      timer    <= '0;
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end else begin
      beep_q <= beep;
      timer  <= timer_nxt;
      if (timer_nxt == '0) begin
        buzzer   <= 1'b0;
        tone_cnt <= '0;
      end else if (timer != '0) begin
        // A retrigger while active keeps the tone phase running.
        if (tone_cnt == TONE_W'(TONE_DIV - 1)) begin
          tone_cnt <= '0;
          buzzer   <= ~buzzer;
        end else begin
          tone_cnt <= tone_cnt + 1'b1;
        end
      end
    end
  end

endmodule
